// File: rtl/label_motion_ctrl.sv
// Position and visibility controller for a 64x16 text label on a 640x480 VGA frame.
// Three modes (IDLE/MOVE/PAUSE) with once-per-frame bounce motion and blink gating.
module label_motion_ctrl #(
  parameter int H_FOOTPRINT  = 64,
  parameter int V_FOOTPRINT  = 16,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int HOME_X       = 288,
  parameter int HOME_Y       = 232,
  parameter int STEP         = 1,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       start,
  input  logic       stop,
  input  logic       home,
  output logic [9:0] top_left_x,
  output logic [9:0] top_left_y,
  output logic       label_en,
  output logic       frame_tick
);

  localparam int XMAX = SCREEN_W - H_FOOTPRINT;
  localparam int YMAX = SCREEN_H - V_FOOTPRINT;
  localparam int BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       fwd;  // 1 = right/down, 0 = left/up
  } axis_t;

  // One bounce step on a single axis; 11-bit math keeps pos+STEP from wrapping.
  function automatic axis_t step_axis(input logic [9:0] pos, input logic fwd,
                                      input logic [10:0] lim);
    axis_t       res;
    logic [10:0] p;
    logic [10:0] s;
    p = {1'b0, pos};
    s = 11'(STEP);
    if (fwd) begin
      if (p + s >= lim) begin
        res.pos = lim[9:0];
        res.fwd = 1'b0;
      end else begin
        res.pos = 10'(p + s);
        res.fwd = 1'b1;
      end
    end else begin
      if (p <= s) begin
        res.pos = 10'd0;
        res.fwd = 1'b1;
      end else begin
        res.pos = 10'(p - s);
        res.fwd = 1'b0;
      end
    end
    return res;
  endfunction

  state_t          state_q, state_d;
  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic            dir_x_q, dir_x_d;
  logic            dir_y_q, dir_y_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            en_q, en_d;
  logic            raw_q, raw_d;
  logic            tick_q, tick_d;

  axis_t           step_x;
  axis_t           step_y;

  assign step_x = step_axis(x_q, dir_x_q, 11'(XMAX));
  assign step_y = step_axis(y_q, dir_y_q, 11'(YMAX));

  // Start of vertical blanking: first pixel of the line after the visible area + 1.
  assign raw_d  = (pixel_y == 10'(SCREEN_H + 1)) && (pixel_x == 10'd0);
  // Edge detect so a slow pixel clock holding raw high still yields one tick.
  assign tick_d = raw_d & ~raw_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    blink_d = blink_q;
    en_d    = en_q;

    if (home) begin
      state_d = IDLE;
      x_d     = 10'(HOME_X);
      y_d     = 10'(HOME_Y);
      dir_x_d = 1'b1;
      dir_y_d = 1'b1;
      blink_d = '0;
      en_d    = 1'b1;
    end else if (stop && state_q == MOVE) begin
      state_d = PAUSE;
      blink_d = '0;
    end else if (start && state_q != MOVE) begin
      state_d = MOVE;
      blink_d = '0;
      en_d    = 1'b1;
    end else if (tick_q) begin
      // An applied transition above takes precedence over this frame's update.
      unique case (state_q)
        MOVE: begin
          x_d     = step_x.pos;
          dir_x_d = step_x.fwd;
          y_d     = step_y.pos;
          dir_y_d = step_y.fwd;
        end
        PAUSE: begin
          if (blink_q == BW'(BLINK_FRAMES - 1)) begin
            blink_d = '0;
            en_d    = ~en_q;
          end else begin
            blink_d = blink_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= 10'(HOME_X);
      y_q     <= 10'(HOME_Y);
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      blink_q <= '0;
      en_q    <= 1'b1;
      raw_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      blink_q <= blink_d;
      en_q    <= en_d;
      raw_q   <= raw_d;
      tick_q  <= tick_d;
    end
  end

  assign top_left_x = x_q;
  assign top_left_y = y_q;
  assign label_en   = en_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_label_motion_ctrl.sv
// Scoreboard bench for label_motion_ctrl: stimulus pushes expected post-frame state,
// a monitor pops and compares on every frame_tick the DUT presents.
module tb_label_motion_ctrl;

  localparam int HOME_X = 288;
  localparam int HOME_Y = 232;
  localparam int XMAX   = 576;
  localparam int YMAX   = 464;
  localparam int STEP   = 1;
  localparam int BLINK  = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pixel_x, pixel_y;
  logic       start, stop, home;
  logic [9:0] top_left_x, top_left_y;
  logic       label_en, frame_tick;

  always #5 clk = ~clk;

  label_motion_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .start      (start),
    .stop       (stop),
    .home       (home),
    .top_left_x (top_left_x),
    .top_left_y (top_left_y),
    .label_en   (label_en),
    .frame_tick (frame_tick)
  );

  typedef struct {
    int x;
    int y;
    int en;
  } exp_t;

  typedef enum {M_IDLE, M_MOVE, M_PAUSE} mode_t;

  exp_t  sb_q[$];
  int    n_checks      = 0;
  int    n_errors      = 0;
  int    frames_issued = 0;
  int    ticks_seen    = 0;

  // Reference model: mode, position, signed velocity per axis, blink count.
  mode_t m_mode;
  int    m_x, m_y, m_dx, m_dy, m_cnt, m_en;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_x = HOME_X; m_y = HOME_Y;
    m_dx = 1; m_dy = 1;
    m_cnt = 0; m_en = 1;
  endfunction

  function automatic bit model_pulse(input bit h, input bit s, input bit st);
    if (h) begin
      model_reset();
      return 1'b1;
    end
    if (s && m_mode == M_MOVE) begin
      m_mode = M_PAUSE; m_cnt = 0;
      return 1'b1;
    end
    if (st && m_mode != M_MOVE) begin
      m_mode = M_MOVE; m_cnt = 0; m_en = 1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Move p by d*STEP, clamping into [0, lim] and reversing on contact.
  function automatic void bounce(inout int p, inout int d, input int lim);
    int n;
    n = p + d * STEP;
    if (d > 0 && n >= lim) begin p = lim; d = -1; end
    else if (d < 0 && n <= 0) begin p = 0; d = 1; end
    else p = n;
  endfunction

  function automatic void model_frame(input bit applied);
    if (applied) return;
    if (m_mode == M_MOVE) begin
      bounce(m_x, m_dx, XMAX);
      bounce(m_y, m_dy, YMAX);
    end else if (m_mode == M_PAUSE) begin
      m_cnt++;
      if (m_cnt == BLINK) begin
        m_cnt = 0;
        m_en  = 1 - m_en;
      end
    end
  endfunction

  task automatic pulse(input bit h, input bit s, input bit st);
    @(negedge clk);
    home = h; stop = s; start = st;
    void'(model_pulse(h, s, st));
    @(negedge clk);
    home = 0; stop = 0; start = 0;
  endtask

  // One frame: enter blanking for 'hold' clocks, optionally with pulses
  // landing on the same cycle the tick is presented.
  task automatic frame(input bit h, input bit s, input bit st, input int hold);
    bit   applied;
    exp_t e;
    @(negedge clk);
    pixel_x = 10'd0; pixel_y = 10'd481;
    @(negedge clk);
    home = h; stop = s; start = st;
    applied = model_pulse(h, s, st);
    model_frame(applied);
    e.x = m_x; e.y = m_y; e.en = m_en;
    sb_q.push_back(e);
    frames_issued++;
    @(negedge clk);
    home = 0; stop = 0; start = 0;
    repeat (hold) @(negedge clk);
    pixel_x = 10'd0; pixel_y = 10'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(0, 0, 0, $urandom_range(0, 3));
  endtask

  // Monitor: each observed tick consumes one expectation, compared after the update edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        ticks_seen++;
        @(negedge clk);
        if (sb_q.size() == 0) begin
          check("unexpected_tick", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("frame_x", int'(top_left_x), e.x);
          check("frame_y", int'(top_left_y), e.y);
          check("frame_en", int'(label_en), e.en);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete, ticks=%0d frames=%0d", ticks_seen, frames_issued);
    $fatal(1);
  end

  initial begin
    int r;
    reset = 1'b1;
    pixel_x = 10'd0; pixel_y = 10'd0;
    start = 0; stop = 0; home = 0;
    model_reset();
    #1;
    check("reset_x", int'(top_left_x), HOME_X);
    check("reset_y", int'(top_left_y), HOME_Y);
    check("reset_en", int'(label_en), 1);
    check("reset_tick", int'(frame_tick), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    frames(2);
    frame(0, 0, 0, 4);

    pulse(0, 0, 1);
    frames(3);
    check("motion_x3", int'(top_left_x), 291);
    check("motion_y3", int'(top_left_y), 235);
    check("motion_en3", int'(label_en), 1);

    // Long run in MOVE reaches all four edges.
    frames(900);

    pulse(0, 1, 0);
    frames(29);
    check("pause_en29", int'(label_en), 1);
    frames(1);
    check("pause_en30", int'(label_en), 0);
    frames(30);
    check("pause_en60", int'(label_en), 1);
    pulse(0, 0, 1);
    check("resume_en", int'(label_en), 1);
    frames(5);

    frame(1, 0, 1, 1);
    check("prio_x", int'(top_left_x), HOME_X);
    check("prio_y", int'(top_left_y), HOME_Y);
    pulse(0, 1, 0);
    frames(2);
    check("stop_idle_x", int'(top_left_x), HOME_X);
    check("stop_idle_en", int'(label_en), 1);

    for (int i = 0; i < 1200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6)
        pulse($urandom_range(0, 5) == 0, $urandom_range(0, 1), $urandom_range(0, 1));
      else if (r < 12)
        frame($urandom_range(0, 5) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 3));
      else
        frame(0, 0, 0, $urandom_range(0, 3));
    end

    // Asynchronous reset mid-cycle, checked before any clock edge.
    pulse(0, 0, 1);
    frames(10);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_x", int'(top_left_x), HOME_X);
    check("midreset_y", int'(top_left_y), HOME_Y);
    check("midreset_en", int'(label_en), 1);
    check("midreset_tick", int'(frame_tick), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    pulse(0, 0, 1);
    frames(4);

    repeat (5) @(negedge clk);
    check("tick_count", ticks_seen, frames_issued);
    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/label_motion_ctrl.md
Name: label_motion_ctrl

Overview:
- Controller that positions and gates one fixed-footprint text label (64x16 px) on the 640x480 VGA display.
- Drives the label renderer's top_left_x/top_left_y and a label enable that the pixel mux ANDs with the renderer's on output.
- Sequences three modes from push-button pulses: static at home, bouncing around the screen, and paused with blinking.
- All motion updates once per frame, at the start of vertical blanking.

Parameters:
H_FOOTPRINT, 64, label width in pixels
V_FOOTPRINT, 16, label height in pixels
SCREEN_W, 640, visible width
SCREEN_H, 480, visible height
HOME_X, 288, home x position (top-left)
HOME_Y, 232, home y position (top-left)
STEP, 1, pixels moved per frame on each axis (1..15)
BLINK_FRAMES, 30, frames per blink half-period in PAUSE

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
pixel_x  input  10  current scan x from VGA sync
pixel_y  input  10  current scan y from VGA sync
start  input  1  one-cycle pulse: begin or resume motion
stop  input  1  one-cycle pulse: pause motion
home  input  1  one-cycle pulse: return to home position, stop
top_left_x  output  10  label x position, registered
top_left_y  output  10  label y position, registered
label_en  output  1  label visibility gate, registered
frame_tick  output  1  one-cycle frame strobe, registered

Behaviour:
- Reset (async, active-high) sets all registers immediately:
  - top_left_x=HOME_X, top_left_y=HOME_Y.
  - dir_x=right, dir_y=down.
  - state=IDLE, label_en=1, frame_tick=0, blink counter=0, edge-detect register=0.
- Frame strobe:
  - raw = (pixel_y==SCREEN_H+1) && (pixel_x==0), registered each clk.
  - frame_tick=1 for exactly one clk, on the cycle after raw rises.
  - Holding raw high for many clk cycles (slow pixel clock) yields one tick only.
- States:
  - IDLE: position held, label_en=1.
  - MOVE: position updates on each frame_tick, label_en=1.
  - PAUSE: position held; label_en toggles every BLINK_FRAMES frame_ticks.
- Transitions, evaluated every clk, priority home > stop > start:
  - home (any state) -> IDLE. Position reloads HOME_X/HOME_Y, directions reset to right/down, blink counter cleared, label_en=1, all next clk.
  - stop in MOVE -> PAUSE. Blink counter cleared, label_en stays 1 until the first toggle.
  - start in IDLE or PAUSE -> MOVE. Blink counter cleared, label_en=1, position unchanged.
  - stop in IDLE/PAUSE and start in MOVE are ignored.
- Motion on frame_tick in MOVE, per axis, using x limit XMAX=SCREEN_W-H_FOOTPRINT (576) and y limit YMAX=SCREEN_H-V_FOOTPRINT (464):
  - Moving right: if x+STEP >= XMAX, set x=XMAX and dir=left; else x=x+STEP.
  - Moving left: if x <= STEP, set x=0 and dir=right; else x=x-STEP.
  - y behaves identically with YMAX and up/down.
  - Axes are independent; a corner hit flips both directions in the same frame.
- Arithmetic is 11-bit internally to avoid wrap; outputs never exceed XMAX/YMAX and never go below 0.
- Simultaneous events:
  - A pulse coinciding with frame_tick is applied and the frame step is suppressed for that cycle.
  - A transition into MOVE takes effect at the next frame_tick.
- Blink counter:
  - Counts frame_ticks in PAUSE; at BLINK_FRAMES-1 it wraps to 0 and label_en inverts.
  - The counter is frozen in IDLE and MOVE.
- Reset asserted mid-motion restores reset values immediately, regardless of clk.

Test Plan:
- Reset: assert reset without clk edges -> top_left_x=288, top_left_y=232, label_en=1, frame_tick=0.
- Frame strobe: hold pixel_x=0, pixel_y=481 for 4 clk -> exactly one frame_tick pulse; return to (0,0) then re-enter (0,481) -> a second pulse.
- Motion: start, then 3 frames -> top_left_x=291, top_left_y=235, label_en=1 throughout.
- Bounce: move to x=575, y=463 dir right/down, then 1 frame -> x=576, y=464, both dirs flip; next frame -> x=575, y=463. Left/top edges: 1 frame from x=1,y=1 moving left/up -> x=0,y=0, dirs flip to right/down.
- Pause/blink: stop in MOVE, 29 frames -> label_en=1, position frozen; 30th frame -> label_en=0; 60th frame -> 1. Then start -> label_en=1, motion resumes from the frozen position.
- Priority: home and start asserted in the same cycle as frame_tick while in MOVE -> state IDLE, position=288/232, no step applied; a later stop alone -> no change.
